// File: rtl/time_set_ctrl_if.sv
// Button/tick inputs and time/mode outputs of the time-setting controller.
interface time_set_ctrl_if;
  logic       TICK;
  logic       BTN_MODE;
  logic       BTN_INC;
  logic [4:0] HOUR;
  logic [5:0] MINUTE;
  logic [5:0] SECOND;
  logic [1:0] MODE;

  modport master (
    output TICK, BTN_MODE, BTN_INC,
    input  HOUR, MINUTE, SECOND, MODE
  );

  modport slave (
    input  TICK, BTN_MODE, BTN_INC,
    output HOUR, MINUTE, SECOND, MODE
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Clock time keeper with button-driven setting of hour, minute and second.
// In RUN, TICK advances the time with a full carry chain. In the SET states
// the time is frozen, BTN_INC bumps the selected field without carry, and an
// idle counter returns the block to RUN after TIMEOUT quiet ticks.
module time_set_ctrl #(
  parameter int TIMEOUT = 10
) (
  input  logic          CLK_IN,
  input  logic          RST_N,
  time_set_ctrl_if.slave bus
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_SET_HOUR = 2'd1;
  localparam logic [1:0] ST_SET_MIN  = 2'd2;
  localparam logic [1:0] ST_SET_SEC  = 2'd3;

  // Idle count at which the next quiet tick times out.
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

  logic [4:0] hour_r,   hour_nxt_s;
  logic [5:0] min_r,    min_nxt_s;
  logic [5:0] sec_r,    sec_nxt_s;
  logic [1:0] mode_r,   mode_nxt_s;
  logic [3:0] idle_r,   idle_nxt_s;
  logic       mode_prev_r;
  logic       inc_prev_r;
  logic       mode_edge_s;
  logic       inc_edge_s;

  // Increment with wrap; any value at or above the limit wraps to zero so
  // that a corrupted field recovers on its next increment.
  function automatic logic [5:0] inc_wrap6(input logic [5:0] v, input logic [5:0] lim);
    return (v >= lim) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc_wrap5(input logic [4:0] v, input logic [4:0] lim);
    return (v >= lim) ? 5'd0 : v + 5'd1;
  endfunction

  assign mode_edge_s = bus.BTN_MODE & ~mode_prev_r;
  assign inc_edge_s  = bus.BTN_INC  & ~inc_prev_r;

  // Next-state logic for time fields, mode and idle counter.
  always_comb begin
    hour_nxt_s = hour_r;
    min_nxt_s  = min_r;
    sec_nxt_s  = sec_r;
    mode_nxt_s = mode_r;
    idle_nxt_s = idle_r;
    case (mode_r)
      ST_RUN: begin
        idle_nxt_s = 4'd0;
        if (bus.TICK) begin
          sec_nxt_s = inc_wrap6(sec_r, 6'd59);
          if (sec_r >= 6'd59) begin
            min_nxt_s = inc_wrap6(min_r, 6'd59);
            if (min_r >= 6'd59) begin
              hour_nxt_s = inc_wrap5(hour_r, 5'd23);
            end else begin
              hour_nxt_s = hour_r;
            end
          end else begin
            min_nxt_s = min_r;
          end
        end else begin
          sec_nxt_s = sec_r;
        end
        if (mode_edge_s) begin
          mode_nxt_s = ST_SET_HOUR;
        end else begin
          mode_nxt_s = ST_RUN;
        end
      end
      ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: begin
        if (mode_edge_s) begin
          // Mode wins over a coincident INC edge; SET_SEC + 1 wraps to RUN.
          mode_nxt_s = mode_r + 2'd1;
          idle_nxt_s = 4'd0;
        end else if (inc_edge_s) begin
          idle_nxt_s = 4'd0;
          case (mode_r)
            ST_SET_HOUR: hour_nxt_s = inc_wrap5(hour_r, 5'd23);
            ST_SET_MIN:  min_nxt_s  = inc_wrap6(min_r, 6'd59);
            ST_SET_SEC:  sec_nxt_s  = inc_wrap6(sec_r, 6'd59);
            default:     hour_nxt_s = hour_r;
          endcase
        end else if (bus.TICK) begin
          if (idle_r == TO_LAST) begin
            mode_nxt_s = ST_RUN;
            idle_nxt_s = 4'd0;
          end else begin
            idle_nxt_s = idle_r + 4'd1;
          end
        end else begin
          idle_nxt_s = idle_r;
        end
      end
      default: begin
        mode_nxt_s = ST_RUN;
        idle_nxt_s = 4'd0;
      end
    endcase
  end

  // State registers, edge-detect history and registered outputs.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      hour_r      <= 5'd0;
      min_r       <= 6'd0;
      sec_r       <= 6'd0;
      mode_r      <= ST_RUN;
      idle_r      <= 4'd0;
      mode_prev_r <= 1'b0;
      inc_prev_r  <= 1'b0;
    end else begin
      hour_r      <= hour_nxt_s;
      min_r       <= min_nxt_s;
      sec_r       <= sec_nxt_s;
      mode_r      <= mode_nxt_s;
      idle_r      <= idle_nxt_s;
      mode_prev_r <= bus.BTN_MODE;
      inc_prev_r  <= bus.BTN_INC;
    end
  end

  assign bus.HOUR   = hour_r;
  assign bus.MINUTE = min_r;
  assign bus.SECOND = sec_r;
  assign bus.MODE   = mode_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed testbench for time_set_ctrl: a vector table plus hand-written
// sequences for carry, wrap, timeout and asynchronous reset behaviour.
module tb_time_set_ctrl;

  logic CLK_IN;
  logic RST_N;
  int   n_checks;
  int   n_fail;

  time_set_ctrl_if bus ();

  time_set_ctrl #(.TIMEOUT(10)) dut (
    .CLK_IN (CLK_IN),
    .RST_N  (RST_N),
    .bus    (bus)
  );

  initial CLK_IN = 1'b0;
  always #5 CLK_IN = ~CLK_IN;

  typedef struct {
    logic       tick;
    logic       bm;
    logic       bi;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [1:0] md;
  } vec_t;

  vec_t vecs[28];

  task automatic check(input string name, input logic [4:0] h, input logic [5:0] m,
                       input logic [5:0] s, input logic [1:0] md);
    n_checks++;
    if (bus.HOUR !== h || bus.MINUTE !== m || bus.SECOND !== s || bus.MODE !== md) begin
      n_fail++;
      $display("FAIL %s: got %0d:%0d:%0d mode %0d, expected %0d:%0d:%0d mode %0d",
               name, bus.HOUR, bus.MINUTE, bus.SECOND, bus.MODE, h, m, s, md);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, sample just after the rising edge.
  task automatic cycle(input logic t, input logic bm, input logic bi);
    @(negedge CLK_IN);
    bus.TICK     = t;
    bus.BTN_MODE = bm;
    bus.BTN_INC  = bi;
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic press_inc(input int n);
    for (int k = 0; k < n; k++) begin
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic press_mode(input int n);
    for (int k = 0; k < n; k++) begin
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK_IN);
    bus.TICK = 1'b0; bus.BTN_MODE = 1'b0; bus.BTN_INC = 1'b0;
    RST_N = 1'b0;
    @(negedge CLK_IN);
    @(negedge CLK_IN);
    RST_N = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST_N    = 1'b1;
    bus.TICK = 1'b0; bus.BTN_MODE = 1'b0; bus.BTN_INC = 1'b0;

    //           tick  bm    bi    h     m     s     md
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'd0, 6'd0, 6'd1, 2'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 6'd1, 2'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 5'd0, 6'd0, 6'd1, 2'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 5'd0, 6'd0, 6'd2, 2'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 5'd0, 6'd0, 6'd2, 2'd1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 5'd0, 6'd0, 6'd2, 2'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 5'd1, 6'd0, 6'd2, 2'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 5'd1, 6'd0, 6'd2, 2'd1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 5'd1, 6'd0, 6'd2, 2'd2};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 5'd1, 6'd0, 6'd2, 2'd2};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 5'd1, 6'd1, 6'd2, 2'd2};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 5'd1, 6'd1, 6'd2, 2'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 5'd1, 6'd1, 6'd2, 2'd2};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 5'd1, 6'd1, 6'd2, 2'd3};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 5'd1, 6'd1, 6'd2, 2'd3};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 5'd1, 6'd1, 6'd3, 2'd3};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 5'd1, 6'd1, 6'd3, 2'd3};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 5'd1, 6'd1, 6'd3, 2'd0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 5'd1, 6'd1, 6'd4, 2'd0};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 5'd1, 6'd1, 6'd4, 2'd1};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 5'd1, 6'd1, 6'd4, 2'd1};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 5'd1, 6'd1, 6'd4, 2'd1};
    vecs[22] = '{1'b0, 1'b1, 1'b0, 5'd1, 6'd1, 6'd4, 2'd2};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 5'd1, 6'd1, 6'd4, 2'd2};
    vecs[24] = '{1'b0, 1'b1, 1'b0, 5'd1, 6'd1, 6'd4, 2'd3};
    vecs[25] = '{1'b0, 1'b0, 1'b0, 5'd1, 6'd1, 6'd4, 2'd3};
    vecs[26] = '{1'b0, 1'b1, 1'b0, 5'd1, 6'd1, 6'd4, 2'd0};
    vecs[27] = '{1'b0, 1'b0, 1'b0, 5'd1, 6'd1, 6'd4, 2'd0};

    do_reset();
    #1;
    check("reset_state", 5'd0, 6'd0, 6'd0, 2'd0);

    for (int i = 0; i < 28; i++) begin
      cycle(vecs[i].tick, vecs[i].bm, vecs[i].bi);
      check($sformatf("vec%0d", i), vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].md);
    end

    // 3661 ticks from reset -> 01:01:01
    do_reset();
    ticks(3661);
    check("run_3661", 5'd1, 6'd1, 6'd1, 2'd0);

    // Preset 23:59:59 through the SET states, then one tick rolls over
    do_reset();
    press_mode(1); press_inc(23);
    press_mode(1); press_inc(59);
    press_mode(1); press_inc(59);
    press_mode(1);
    check("preset_235959", 5'd23, 6'd59, 6'd59, 2'd0);
    ticks(1);
    check("rollover_000000", 5'd0, 6'd0, 6'd0, 2'd0);

    // Hour wrap in SET_HOUR with ticks interleaved: 00:02:05 -> 25 INC -> 01:02:05
    do_reset();
    ticks(125);
    press_mode(1);
    for (int k = 0; k < 25; k++) begin
      cycle(1'b0, 1'b0, 1'b1);
      cycle((k < 5) ? 1'b1 : 1'b0, 1'b0, 1'b0);
    end
    check("set_hour_wrap", 5'd1, 6'd2, 6'd5, 2'd1);

    // Minute wrap in SET_MIN, no carry into hour
    press_mode(1);
    press_inc(57);
    check("set_min_59", 5'd1, 6'd59, 6'd5, 2'd2);
    press_inc(1);
    check("set_min_wrap", 5'd1, 6'd0, 6'd5, 2'd2);

    // Timeout from SET_SEC: 9 ticks stay, 10th returns to RUN, next tick counts
    press_mode(1);
    ticks(9);
    check("timeout_9", 5'd1, 6'd0, 6'd5, 2'd3);
    ticks(1);
    check("timeout_10", 5'd1, 6'd0, 6'd5, 2'd0);
    ticks(1);
    check("first_tick_after", 5'd1, 6'd0, 6'd6, 2'd0);

    // INC edge on the 10th tick suppresses the timeout and restarts the count
    press_mode(3);
    ticks(9);
    cycle(1'b1, 1'b0, 1'b1);
    check("suppress_10", 5'd1, 6'd0, 6'd7, 2'd3);
    cycle(1'b0, 1'b0, 1'b0);
    ticks(9);
    check("suppress_then_9", 5'd1, 6'd0, 6'd7, 2'd3);
    ticks(1);
    check("suppress_then_10", 5'd1, 6'd0, 6'd7, 2'd0);

    // Asynchronous reset in SET_MIN at 12:34:56
    do_reset();
    press_mode(1); press_inc(12);
    press_mode(1); press_inc(34);
    press_mode(1); press_inc(56);
    press_mode(3);
    check("pre_reset_123456", 5'd12, 6'd34, 6'd56, 2'd2);
    @(negedge CLK_IN);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_reset", 5'd0, 6'd0, 6'd0, 2'd0);
    bus.BTN_MODE = 1'b1;
    @(negedge CLK_IN);
    @(negedge CLK_IN);
    RST_N = 1'b1;
    #1;
    check("reset_release", 5'd0, 6'd0, 6'd0, 2'd0);
    @(posedge CLK_IN);
    #1;
    check("held_btn_edge", 5'd0, 6'd0, 6'd0, 2'd1);
    cycle(1'b0, 1'b1, 1'b0);
    check("held_btn_once", 5'd0, 6'd0, 6'd0, 2'd1);
    cycle(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 10, is the number of TICK pulses with no button edge after which a SET state returns to RUN; legal range 1..15.
REQ-002 CLK_IN  input  1  system clock; all state changes on its rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 TICK  input  1  one-cycle pulse, one per second, synchronous to CLK_IN.
REQ-005 BTN_MODE  input  1  mode button level, already debounced and synchronous.
REQ-006 BTN_INC  input  1  increment button level, already debounced and synchronous.
REQ-007 HOUR  output  5  current hour, 0..23.
REQ-008 MINUTE  output  6  current minute, 0..59.
REQ-009 SECOND  output  6  current second, 0..59.
REQ-010 MODE  output  2  current state encoding: 0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC.

Function
REQ-011 Rising-edge detection: one register per button; the edge is button=1 while the registered previous value=0; a held button yields exactly one edge.
REQ-012 States and BTN_MODE edges: RUN->SET_HOUR->SET_MIN->SET_SEC->RUN, one step per BTN_MODE edge; MODE updates on the clock edge after the button rises.
REQ-013 RUN, TICK=1: SECOND increments; at 59 it wraps to 0 and MINUTE increments.
REQ-014 RUN carry chain: MINUTE wraps 59->0 and carries to HOUR; HOUR wraps 23->0; 23:59:59 plus TICK gives 00:00:00 in one cycle.
REQ-015 RUN, TICK=0: time holds; BTN_INC edges have no effect in RUN.
REQ-016 SET states: time is frozen; TICK does not advance time; TICK only advances the idle counter.
REQ-017 SET states, BTN_INC edge: only the selected field increments by 1, with wrap and no carry (HOUR 23->0, MINUTE 59->0, SECOND 59->0).
REQ-018 Entering SET_SEC leaves SECOND unchanged; there is no implicit clear.
REQ-019 Simultaneous BTN_MODE and BTN_INC edges: the BTN_MODE edge wins, state advances, and the BTN_INC edge is discarded with no field change.
REQ-020 Idle counter width and clearing: 4 bits; cleared to 0 on any button edge, on any state change and while in RUN.
REQ-021 Idle counter increment: in a SET state, TICK with no button edge in the same cycle increments it.
REQ-022 Timeout: in a SET state, TICK with idle counter == TIMEOUT-1 and no button edge -> state RUN, counter 0, time unchanged.
REQ-023 Timeout vs button edge: a button edge in the same cycle as the timeout TICK suppresses the timeout, and the edge is processed.
REQ-024 First-tick rule: the first TICK after returning to RUN, by button or timeout, advances time normally.
REQ-025 Values out of range are unreachable; if any field is >= its max, the next increment, whether by TICK or INC, wraps it to 0.
REQ-026 All outputs are registered, with no combinational path from input to output.

Reset
REQ-027 RST_N=0 forces immediately, without waiting for a clock: HOUR=0, MINUTE=0, SECOND=0, MODE=0 (RUN), idle counter=0, both edge-detect registers=0.
REQ-028 Reset asserted mid-SET clears everything as in REQ-027; after release the block is in RUN.
REQ-029 Button held high across reset release produces one edge on the first clock after release.

Verification
REQ-030 Reset, then 3661 TICKs in RUN -> HOUR=1, MINUTE=1, SECOND=1, MODE=0.
REQ-031 Time preset to 23:59:59 in RUN, then one TICK -> 00:00:00 in the same cycle.
REQ-032 Set-hour wrap: BTN_MODE edge (MODE=1), then 25 BTN_INC edges -> HOUR=1, MINUTE and SECOND unchanged; 5 TICKs in between -> SECOND unchanged.
REQ-033 Set-minute wrap: MODE=2, MINUTE=59, one BTN_INC edge -> MINUTE=0, HOUR unchanged.
REQ-034 Simultaneous edges: MODE=1, BTN_MODE and BTN_INC rise in the same cycle -> MODE=2, HOUR unchanged.
REQ-035 Timeout: TIMEOUT=10, MODE=3, 9 TICKs -> MODE=3; 10th TICK -> MODE=0; next TICK -> SECOND+1.
REQ-036 Timeout suppression: BTN_INC edge on the 10th TICK -> MODE stays 3, SECOND+1, and 10 further TICKs are needed to time out.
REQ-037 Reset during SET: RST_N pulsed low with MODE=2 and time 12:34:56 -> all outputs 0 asynchronously, MODE=0.
